sha_msg_mem_reader: RTL and testbench
=====================================

Name: sha_msg_mem_reader

Overview:
- Avalon-MM read master for the 32-bit single-port on-chip message memory (16-bit word address, byteenable, chipselect/write, 1-cycle fixed read latency).
- Fetches a programmed run of consecutive words and presents them as a valid/ready stream to the SHA-2 core message-schedule input.
- Uses a credit-counted output FIFO, so memory reads never stall mid-flight and backpressure never loses data.

Parameters:
ADDR_W, 16, word-address width of the memory port.
DATA_W, 32, data width.
READ_LATENCY, 1, cycles from a chipselect cycle to valid mem_readdata.
FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+2; power of two.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
base_addr  in  ADDR_W  first word address; latched on accepted start.
word_count  in  16  number of words to fetch; latched on accepted start.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse when the final word is accepted downstream, or when a zero-length start is accepted.
mem_address  out  ADDR_W  word address to memory.
mem_chipselect  out  1  read strobe.
mem_write  out  1  tied 0.
mem_byteenable  out  DATA_W/8  tied all ones.
mem_clken  out  1  tied 1.
mem_readdata  in  DATA_W  memory read data.
out_data  out  DATA_W  stream word.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready from the SHA core.
out_last  out  1  high with the final word of the run.

Behaviour:
- Reset values (reset_n low, asynchronous): busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_data=0, out_last=0. State goes to IDLE, all counters clear, FIFO is empty.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start with word_count!=0: latch base_addr/word_count, go to ISSUE.
  - start with word_count==0: done pulses the next cycle, busy stays 0, no memory access, no stream output.
- ISSUE:
  - Issue rule: assert mem_chipselect with mem_address=current address when credits>0. credits = FIFO_DEPTH - (FIFO occupancy + reads in flight).
  - Each issued read increments the address and the issued count.
  - After the issue whose issued count equals word_count, go to DRAIN.
  - mem_chipselect is low in any cycle where credits are 0.
- Read pipeline: a READ_LATENCY-deep valid shift register tracks in-flight reads. mem_readdata is pushed into the FIFO when the tail stage is set. A push can never meet a full FIFO, because the credit was reserved at issue.
- Stream: out_data/out_valid come from the FIFO head. A word pops when out_valid & out_ready. out_last is asserted with the word whose popped count equals word_count.
- Latency with out_ready=1: start accepted at cycle 0 -> first chipselect at cycle 1 -> out_valid at cycle 1+READ_LATENCY+1. Throughput is 1 word/clk.
- DRAIN: when the last word pops, go to FIN.
- FIN: done=1 for one cycle, busy falls in the same cycle, return to IDLE. A new start is accepted in the following cycle.
- start while busy: ignored; latched values are unchanged.
- Address wrap: the counter wraps modulo 2^ADDR_W (0xFFFF -> 0x0000). No range check against memory depth.
- word_count: full 16-bit range is legal (1..65535).
- Reset mid-operation: aborts immediately. In-flight read data is discarded (valid pipeline cleared), FIFO is flushed, and no done pulse is produced.
- out_data holds the head value while out_valid=1 and out_ready=0. Stream signals must be stable under backpressure.

Test Plan:
- base=0x0010, count=4, memory preloaded with word i = 0xA0000000+i, out_ready=1 -> chipselect on cycles 1-4 with addresses 0x10-0x13; out_data 0xA0000010..13 on consecutive cycles starting cycle 3; out_last on the 4th word; done the cycle after.
- count=16, out_ready toggling 1,0,0,1 -> all 16 words delivered in order, no duplicates or drops; chipselect stops whenever occupancy+in-flight=4; data stable while out_ready=0.
- start with count=0 -> done pulses once, busy stays 0, mem_chipselect never asserted.
- base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; out_last on the 4th word.
- count=8, reset_n low for 1 cycle after the 3rd word pops -> all outputs return to reset values; no further out_valid and no done pulse; a fresh start (base=0, count=2) then runs normally.
- Second start pulsed while busy -> ignored; the original run completes with the original base/count; a start one cycle after done is accepted.

Source files
------------

// File: rtl/sha_msg_mem_reader.sv
`default_nettype none
// ============================================================================
// sha_msg_mem_reader
//   Avalon-MM read master that streams a run of message words to the SHA core.
//   Revision: 1.0
// ============================================================================
module sha_msg_mem_reader #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr;
    logic [15:0]             r_count;
    logic [15:0]             r_issued;
    logic [15:0]             r_popped;
    logic [CNT_W-1:0]        r_credits;
    logic [CNT_W-1:0]        r_occ;
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [DATA_W-1:0]       r_fifo [FIFO_DEPTH];

    logic                    w_start_run;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_pop;
    logic [ADDR_W-1:0]       w_issue_addr;
    logic [15:0]             w_issued_next;

    // The first read goes out straight from IDLE so chipselect follows start by one cycle.
    assign w_start_run   = (r_state == S_IDLE) && start && (word_count != 16'd0);
    assign w_issue       = w_start_run || ((r_state == S_ISSUE) && (r_credits != '0));
    assign w_issue_addr  = (r_state == S_IDLE) ? base_addr : r_addr;
    assign w_issued_next = (r_state == S_IDLE) ? 16'd1 : (r_issued + 16'd1);

    assign w_push     = r_rd_pipe[READ_LATENCY-1];
    assign w_pop      = out_valid && out_ready;
    assign w_last_pop = w_pop && ((r_popped + 16'd1) == r_count);

    assign out_valid = (r_occ != '0);
    assign out_data  = r_fifo[r_rptr];
    assign out_last  = out_valid && ((r_popped + 16'd1) == r_count);

    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_count        <= '0;
            r_issued       <= '0;
            r_popped       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
        end else begin
            mem_chipselect <= w_issue;
            done           <= 1'b0;

            if (w_issue) begin
                mem_address <= w_issue_addr;
                r_addr      <= w_issue_addr + ADDR_W'(1);
                r_issued    <= w_issued_next;
            end

            if (w_pop) begin
                r_popped <= r_popped + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count != 16'd0) begin
                            r_count  <= word_count;
                            r_popped <= '0;
                            busy     <= 1'b1;
                            r_state  <= (word_count == 16'd1) ? S_DRAIN : S_ISSUE;
                        end else begin
                            // Zero-length run: report completion without touching memory.
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue && (w_issued_next == r_count)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Credits are reserved at issue and returned at pop, so a push never meets a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pipe <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_credits <= C_DEPTH;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= mem_chipselect;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end

            if (w_push) begin
                r_fifo[r_wptr] <= mem_readdata;
                r_wptr         <= r_wptr + PTR_W'(1);
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end

            r_occ     <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            r_credits <= r_credits - CNT_W'(w_issue) + CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_mem_reader.sv
`default_nettype none
// Scoreboard bench for sha_msg_mem_reader: expected addresses and words are queued at start,
// a negedge monitor pops and compares them whenever the DUT presents a read or a stream word.
module tb_sha_msg_mem_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata = 32'h0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;

    sha_msg_mem_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: single port, one-cycle read latency.
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues: filled by stimulus, drained by the monitor.
    logic [15:0] exp_addr [$];
    logic [32:0] exp_word [$];   // {last, data}

    int ready_mode = 0;          // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int run_start_cyc = 0;

    always @(posedge clk) begin
        int ph;
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        ph++;
    end

    // Monitor
    int          first_cs  = -1;
    int          first_val = -1;
    int          done_cyc  = -1;
    int          done_cnt  = 0;
    int          pops_seen = 0;
    int          iss_tot   = 0;
    int          pop_tot   = 0;
    bit          stall_prev = 1'b0;
    logic [32:0] stall_word;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            iss_tot    = 0;
            pop_tot    = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_word", 64'({out_last, out_data}), 64'(stall_word));
            end
            if (mem_chipselect) begin
                iss_tot++;
                chk("credit_limit", 64'((iss_tot - pop_tot) <= 4), 64'd1);
                if (first_cs < run_start_cyc) first_cs = cyc;
                chk("cs_expected", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) chk("mem_address", 64'(mem_address), 64'(exp_addr.pop_front()));
                chk("mem_ctl", 64'({mem_write, mem_byteenable, mem_clken}), 64'h1F);
            end
            if (out_valid && (first_val < run_start_cyc)) first_val = cyc;
            if (out_valid && out_ready) begin
                pop_tot++;
                pops_seen++;
                chk("word_expected", 64'(exp_word.size() != 0), 64'd1);
                if (exp_word.size() != 0) chk("out_word", 64'({out_last, out_data}), 64'(exp_word.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            stall_word = {out_last, out_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    int exp_done = 0;

    // Push the expected transaction, pulse start, wait (bounded) for done.
    task automatic do_run(input logic [15:0] base, input logic [15:0] cnt, input int mode,
                          input bit check_lat, input bit busy_start);
        int d0;
        int s;
        int guard;
        ready_mode = mode;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            exp_addr.push_back(a);
            exp_word.push_back({(i == int'(cnt) - 1), mem[a]});
        end
        d0 = done_cnt;
        s  = cyc;
        run_start_cyc = s;
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while ((done_cnt == d0) && (guard < 200 + 8 * int'(cnt))) begin
            if (busy_start && guard == 3) begin
                start = 1'b1;
                base_addr = 16'h5555;
                word_count = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (cnt == 16'd0) chk("zero_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        chk("run_done_seen", 64'(done_cnt - d0), 64'd1);
        chk("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
        chk("word_queue_empty", 64'(exp_word.size()), 64'd0);
        exp_addr.delete();
        exp_word.delete();
        exp_done++;
        if (check_lat) begin
            chk("lat_first_cs", 64'(first_cs - s), 64'd1);
            chk("lat_first_valid", 64'(first_val - s), 64'd3);
            chk("lat_done", 64'(done_cyc - s), 64'(int'(cnt) + 3));
        end
        if (cnt == 16'd0) chk("zero_done_cycle", 64'(done_cyc - s), 64'd1);
    endtask

    task automatic reset_mid_run();
        int p0;
        int d0;
        int guard;
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(16'h0040 + 16'(i));
            exp_word.push_back({(i == 7), mem[16'h0040 + 16'(i)]});
        end
        p0 = pops_seen;
        run_start_cyc = cyc;
        start = 1'b1;
        base_addr = 16'h0040;
        word_count = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while ((pops_seen < p0 + 3) && (guard < 100)) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reset_pops_before", 64'(pops_seen - p0), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 64'({busy, done, mem_chipselect, mem_address, out_valid, out_data, out_last}), 64'd0);
        exp_addr.delete();
        exp_word.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("reset_no_done", 64'(done_cnt - d0), 64'd0);
        chk("reset_idle", 64'({busy, out_valid}), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, mem_chipselect, mem_address, out_valid, out_data, out_last}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_run(16'h0010, 16'd4, 0, 1'b1, 1'b0);
        do_run(16'h0100, 16'd16, 1, 1'b0, 1'b0);
        do_run(16'h0200, 16'd0, 0, 1'b0, 1'b0);
        do_run(16'hFFFE, 16'd4, 0, 1'b0, 1'b0);
        reset_mid_run();
        do_run(16'h0000, 16'd2, 0, 1'b1, 1'b0);
        do_run(16'h0300, 16'd6, 1, 1'b0, 1'b1);
        do_run(16'h0400, 16'd3, 0, 1'b1, 1'b0);   // starts the cycle right after done

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int r = 0; r < 12; r++) begin
            logic [15:0] b;
            logic [15:0] c;
            b = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
            c = 16'($urandom_range(1, 40));
            do_run(b, c, $urandom_range(0, 2), 1'b0, 1'b0);
        end

        chk("total_done", 64'(done_cnt), 64'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
